// File: rtl/vga_pkg.sv
// Shared types and default geometry for the VGA video-RAM arbiter.
package vga_pkg;

  localparam int unsigned H_DISP     = 640;
  localparam int unsigned V_DISP     = 480;
  localparam int unsigned ADDR_W     = 20;
  localparam int unsigned DATA_W     = 12;
  localparam int unsigned BUF_OFFSET = 307200;
  localparam int unsigned FIFO_DEPTH = 4;

  // One queued host write.
  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } vram_wr_t;

  typedef enum logic [0:0] {
    SWAP_IDLE,
    SWAP_PENDING
  } swap_state_t;

endpackage

// File: rtl/vga_vram_arbiter_if.sv
// Host pixel-write channel: valid/ready handshake plus the blank-only drain policy.
interface vga_vram_arbiter_if;
  import vga_pkg::*;

  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_blank_only;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_blank_only,
    input  wr_ready
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_blank_only,
    output wr_ready
  );

endinterface

// File: rtl/vram_wr_fifo.sv
// Small synchronous FIFO holding host writes until a free VRAM cycle appears.
module vram_wr_fifo
  import vga_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic     clk,
  input  logic     reset,
  input  logic     push,
  input  vram_wr_t push_data,
  input  logic     pop,
  output vram_wr_t head,
  output logic     full,
  output logic     empty
);

  localparam int unsigned PtrW = $clog2(DEPTH);

  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]   count_q;
  vram_wr_t        mem_q [DEPTH];

  logic do_push, do_pop;

  assign full    = (count_q == (PtrW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array; contents need no reset because the pointers gate them.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/vga_vram_arbiter.sv
// Shares a single-port VRAM between display refresh reads and queued host writes,
// and manages the double-buffered front/back frame swap at the start of vblank.
// Optional host stall counter enabled by defining VGA_VRAM_ARB_STATS_EN.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int unsigned H_DISP     = vga_pkg::H_DISP,
  parameter int unsigned V_DISP     = vga_pkg::V_DISP,
  parameter int unsigned BUF_OFFSET = vga_pkg::BUF_OFFSET,
  parameter int unsigned FIFO_DEPTH = vga_pkg::FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p_tick,
  input  logic              video_on,
  input  logic [9:0]        x,
  input  logic [9:0]        y,
  vga_vram_arbiter_if.slave host,
  input  logic              swap_req,
  output logic              swap_ack,
  output logic              front_buf,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] pix_data,
  output logic              pix_valid,
  output logic [31:0]       stall_count
);

  localparam logic [9:0] YBlank = 10'(V_DISP);

  logic        fifo_full, fifo_empty, push, pop;
  vram_wr_t    head, push_data;
  logic        disp_slot, host_slot, blank_ok;
  logic [ADDR_W-1:0] disp_addr;

  swap_state_t state_q, state_d;
  logic        swap_point, do_swap;
  logic        front_q, swap_ack_q;

  logic              rd_q, pix_valid_q;
  logic [DATA_W-1:0] pix_data_q;

  // ---------------------------------------------------------------------------
  // Host write queue
  // ---------------------------------------------------------------------------
  assign host.wr_ready = !reset && !fifo_full;
  assign push          = host.wr_valid && host.wr_ready;
  assign push_data     = '{addr: host.wr_addr, data: host.wr_data};

  vram_wr_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  // ---------------------------------------------------------------------------
  // Arbitration: a display read owns any visible pixel tick, host writes fill the rest
  // ---------------------------------------------------------------------------
  assign disp_addr = ADDR_W'(y) * ADDR_W'(H_DISP) + ADDR_W'(x) +
                     (front_q ? ADDR_W'(BUF_OFFSET) : '0);
  assign disp_slot = !reset && p_tick && video_on;
  assign blank_ok  = !host.wr_blank_only || (y >= YBlank);
  assign host_slot = !reset && !disp_slot && !fifo_empty && blank_ok;
  assign pop       = host_slot;

  // Drive the single VRAM port from whichever slot won this cycle.
  always_comb begin
    mem_en    = disp_slot || host_slot;
    mem_we    = host_slot;
    mem_addr  = disp_slot ? disp_addr : head.addr;
    mem_wdata = head.data;
  end

  // ---------------------------------------------------------------------------
  // Pixel capture: read data arrives one cycle after the read, shown the cycle after
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_q        <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
    end else begin
      rd_q        <= disp_slot;
      pix_valid_q <= rd_q;
      if (rd_q) pix_data_q <= mem_rdata;
    end
  end

  assign pix_data  = pix_data_q;
  assign pix_valid = pix_valid_q;

  // ---------------------------------------------------------------------------
  // Swap FSM
  // ---------------------------------------------------------------------------
  assign swap_point = p_tick && (x == '0) && (y == YBlank);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= SWAP_IDLE;
    else       state_q <= state_d;
  end

  // Next state: a request landing on the swap point is served at once, no pending needed.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SWAP_IDLE:    if (swap_req && !swap_point) state_d = SWAP_PENDING;
      SWAP_PENDING: if (swap_point) state_d = SWAP_IDLE;
      default:      state_d = SWAP_IDLE;
    endcase
  end

  // Output decode: swap happens on the swap point when one is requested or pending.
  always_comb begin
    do_swap = swap_point && ((state_q == SWAP_PENDING) || swap_req);
  end

  // Front buffer select and one-cycle acknowledge.
  always_ff @(posedge clk) begin
    if (reset) begin
      front_q    <= 1'b0;
      swap_ack_q <= 1'b0;
    end else begin
      swap_ack_q <= do_swap;
      if (do_swap) front_q <= !front_q;
    end
  end

  assign front_buf = front_q;
  assign swap_ack  = swap_ack_q;

  // ---------------------------------------------------------------------------
  // Host stall statistics
  // ---------------------------------------------------------------------------
`ifdef VGA_VRAM_ARB_STATS_EN
  logic [31:0] stall_q;

  // Saturating count of cycles the host is held off by a full queue.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
    end else if (host.wr_valid && !host.wr_ready && (stall_q != 32'hFFFF_FFFF)) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_count = stall_q;
`else
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Scoreboard bench for vga_vram_arbiter: directed scenarios followed by random traffic.
module tb_vga_vram_arbiter;
  import vga_pkg::*;

`ifdef VGA_VRAM_ARB_STATS_EN
  localparam bit StatsOn = 1'b1;
`else
  localparam bit StatsOn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset, p_tick, video_on, swap_req;
  logic [9:0]        x, y;
  logic              swap_ack, front_buf, mem_en, mem_we, pix_valid;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata, pix_data;
  logic [31:0]       stall_count;

  vga_vram_arbiter_if host ();

  vga_vram_arbiter dut (
    .clk         (clk),
    .reset       (reset),
    .p_tick      (p_tick),
    .video_on    (video_on),
    .x           (x),
    .y           (y),
    .host        (host),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .front_buf   (front_buf),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state (expectations for the current cycle).
  bit          exp_ready, exp_disp, exp_host, exp_pv, exp_front, exp_ack;
  int          exp_addr;
  logic [31:0] exp_stall;
  bit          pending, h_a;
  vram_wr_t    wq[$];
  logic [11:0] pixq[$];
  logic [11:0] vram[int];
  bit          rd_pend;
  int          rd_addr;
  // Previous-cycle decisions, committed at the start of the next cycle.
  bit          p_reset = 1'b1;
  bit          p_disp, p_valid, p_ready, p_do_swap, p_swapreq;
  int          p_addr;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 30) $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // VRAM contents: written locations remember data, others hold an address hash.
  function automatic logic [11:0] lookup(input int a);
    if (vram.exists(a)) return vram[a];
    return 12'(a ^ (a >> 7) ^ 'h5a5);
  endfunction

  // One clock of stimulus; model advances from the previous cycle, then predicts this one.
  task automatic step(input bit rst, input bit pt, input bit von, input int xi, input int yi,
                      input bit v, input int a, input int d, input bit bo, input bit sr);
    bit do_swap;
    @(posedge clk);
    #1;
    if (p_reset) begin
      wq.delete();
      pixq.delete();
      exp_front = 1'b0;
      exp_ack   = 1'b0;
      pending   = 1'b0;
      exp_stall = '0;
    end else begin
      exp_ack = p_do_swap;
      if (p_do_swap) begin
        exp_front = !exp_front;
        pending   = 1'b0;
      end else if (p_swapreq) begin
        pending = 1'b1;
      end
      if (p_valid && !p_ready && exp_stall != 32'hFFFF_FFFF) exp_stall = exp_stall + 1;
    end
    exp_pv = h_a && !p_reset;
    h_a    = p_disp;
    if (p_disp) pixq.push_back(lookup(p_addr));
    mem_rdata = rd_pend ? lookup(rd_addr) : 12'($urandom);

    reset              = rst;
    p_tick             = pt;
    video_on           = von;
    x                  = 10'(xi);
    y                  = 10'(yi);
    host.wr_valid      = v;
    host.wr_addr       = 20'(a);
    host.wr_data       = 12'(d);
    host.wr_blank_only = bo;
    swap_req           = sr;

    exp_ready = !rst && (wq.size() < FIFO_DEPTH);
    exp_disp  = !rst && pt && von;
    exp_host  = !rst && !exp_disp && (wq.size() > 0) && (!bo || yi >= V_DISP);
    exp_addr  = ((exp_front ? BUF_OFFSET : 0) + yi * H_DISP + xi) % (1 << ADDR_W);
    do_swap   = !rst && pt && xi == 0 && yi == V_DISP && (pending || sr);
    if (v && exp_ready) wq.push_back('{addr: 20'(a), data: 12'(d)});

    p_reset   = rst;
    p_disp    = exp_disp;
    p_valid   = v;
    p_ready   = exp_ready;
    p_do_swap = do_swap;
    p_swapreq = sr && !rst;
    p_addr    = exp_addr;
  endtask

  task automatic idle(input int yi, input bit bo);
    step(0, 0, 0, 100, yi, 0, 0, 0, bo, 0);
  endtask

  // Monitor: compares every DUT output against the model on the falling edge.
  always @(negedge clk) begin
    vram_wr_t e;
    chk("wr_ready", 32'(host.wr_ready), 32'(exp_ready));
    chk("mem_en", 32'(mem_en), 32'(exp_disp || exp_host));
    chk("mem_we", 32'(mem_we), 32'(exp_host));
    rd_pend = 1'b0;
    if (mem_en && !mem_we) begin
      chk("rd_addr", 32'(mem_addr), 32'(exp_addr));
      rd_pend = 1'b1;
      rd_addr = int'(mem_addr);
    end
    if (mem_en && mem_we) begin
      if (wq.size() == 0) begin
        chk("wr_queue_entries", 32'(wq.size()), 32'd1);
      end else begin
        e = wq.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(e.addr));
        chk("wr_data", 32'(mem_wdata), 32'(e.data));
        vram[int'(mem_addr)] = mem_wdata;
      end
    end
    chk("pix_valid", 32'(pix_valid), 32'(exp_pv));
    if (pix_valid) begin
      if (pixq.size() == 0) chk("pix_queue_entries", 32'(pixq.size()), 32'd1);
      else chk("pix_data", 32'(pix_data), 32'(pixq.pop_front()));
    end
    chk("front_buf", 32'(front_buf), 32'(exp_front));
    chk("swap_ack", 32'(swap_ack), 32'(exp_ack));
    chk("stall_count", stall_count, StatsOn ? exp_stall : 32'd0);
  end

  initial begin
    logic [11:0] pix_exp;
    int          we_cnt;

    // Reset and reset state.
    for (int i = 0; i < 3; i++) step(1, 1, 1, i, 0, 1, 0, 0, 0, 1);
    idle(100, 0);
    #2;
    chk("rst_pix_data", 32'(pix_data), 32'd0);
    chk("rst_stall", stall_count, 32'd0);
    chk("rst_front", 32'(front_buf), 32'd0);

    // Display read at x=5, y=2 on buffer 0.
    step(0, 1, 1, 5, 2, 0, 0, 0, 0, 0);
    #2;
    chk("addr_5_2", 32'(mem_addr), 32'd1285);
    chk("we_5_2", 32'(mem_we), 32'd0);
    pix_exp = lookup(1285);
    idle(2, 0);
    idle(2, 0);
    #2;
    chk("pix_valid_5_2", 32'(pix_valid), 32'd1);
    chk("pix_data_5_2", 32'(pix_data), 32'(pix_exp));
    idle(2, 0);

    // Blank-only writes pushed in the visible area: queue fills then stalls the host.
    for (int i = 0; i < 4; i++) step(0, 0, 0, i, 100, 1, 100 + i, 'h100 + i, 1, 0);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 20, 100, 1, 200, 'h200, 1, 0);
      if (i == 0) begin
        #2;
        chk("full_ready", 32'(host.wr_ready), 32'd0);
        chk("full_no_we", 32'(mem_we), 32'd0);
      end
    end
    idle(100, 1);
    #2;
    chk("stall_10", stall_count, StatsOn ? 32'd10 : 32'd0);
    // Vertical blank releases the queue, one write per cycle in order.
    for (int i = 0; i < 5; i++) idle(480 + i, 1);

    // Swap request mid-frame, served at the start of vblank.
    step(0, 1, 1, 10, 200, 0, 0, 0, 0, 1);
    idle(300, 0);
    step(0, 1, 0, 0, V_DISP, 0, 0, 0, 0, 1);
    idle(480, 0);
    #2;
    chk("swap_ack_pulse", 32'(swap_ack), 32'd1);
    chk("front_toggled", 32'(front_buf), 32'd1);
    idle(480, 0);
    #2;
    chk("swap_ack_single", 32'(swap_ack), 32'd0);
    step(0, 1, 1, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk("addr_front1", 32'(mem_addr), 32'd307200);
    idle(0, 0);
    idle(0, 0);

    // Reset with three queued writes and a read in flight.
    for (int i = 0; i < 3; i++) step(0, 0, 0, i, 100, 1, 300 + i, 'h300 + i, 1, 0);
    step(0, 1, 1, 299, 100, 0, 0, 0, 1, 0);
    step(1, 1, 1, 300, 100, 0, 0, 0, 1, 0);
    we_cnt = 0;
    for (int i = 0; i < 4; i++) begin
      idle(490, 0);
      #2;
      if (mem_we) we_cnt++;
      if (i == 0) chk("rst_pix_valid", 32'(pix_valid), 32'd0);
    end
    chk("no_we_after_rst", 32'(we_cnt), 32'd0);

    // Random traffic.
    begin
      bit bo;
      bo = 1'b0;
      for (int i = 0; i < 4000; i++) begin
        int r, xi, yi;
        bit pt, von;
        if (i % 64 == 0) bo = $urandom_range(0, 1) == 1;
        pt = (i % 4) == 0;
        r  = $urandom_range(0, 15);
        if (r == 0) begin
          xi = 0;
          yi = V_DISP;
        end else if (r < 8) begin
          xi = $urandom_range(0, H_DISP - 1);
          yi = $urandom_range(0, V_DISP - 1);
        end else begin
          xi = $urandom_range(0, 799);
          yi = $urandom_range(0, 524);
        end
        von = (xi < H_DISP) && (yi < V_DISP);
        step($urandom_range(0, 400) == 0, pt, von, xi, yi, $urandom_range(0, 2) != 0,
             $urandom_range(0, (1 << ADDR_W) - 1), $urandom_range(0, 4095), bo,
             $urandom_range(0, 40) == 0);
      end
    end
    for (int i = 0; i < 8; i++) idle(500, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
